// File: rtl/prv32_muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
package prv32_muldiv_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam int          ITERS    = 32;
    localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN  = 32'h8000_0000;

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

endpackage

// File: rtl/prv32_muldiv_seq_div_step.sv
// One restoring-divide step: shift the next dividend bit into the remainder and
// subtract the divisor when it fits.
module prv32_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic [XLEN-1:0] quo_next
);

    logic [XLEN:0] trial;
    logic [XLEN:0] diff;

    always_comb begin
        trial = {rem, quo[XLEN-1]};
        diff  = trial - {1'b0, divisor};
        if (trial >= {1'b0, divisor}) begin
            rem_next = diff[XLEN-1:0];
            quo_next = {quo[XLEN-2:0], 1'b1};
        end else begin
            rem_next = trial[XLEN-1:0];
            quo_next = {quo[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/prv32_muldiv_seq.sv
// Multi-cycle RV32M mul/div/rem sequencer on one 64-bit accumulator.
// PRV32_FAST_MUL_EN selects a single-cycle multiplier instead of shift-add.
module prv32_muldiv_seq
    import prv32_muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result,
    output logic            done,
    output logic            busy,
    output logic            stall
);

    state_t state, state_next;

    logic [2:0]      f3_q;
    logic [XLEN-1:0] mag_a, mag_b;
    logic            neg_q;
    logic [63:0]     acc;
    logic [4:0]      cnt;

    logic            accept, is_div, a_signed, b_signed, res_sign;
    logic            div_zero, div_ovf, special;
    logic [XLEN-1:0] abs_a, abs_b, special_res;
    logic [XLEN:0]   mul_sum;
    logic [63:0]     mul_next, prod;
    logic [XLEN-1:0] rem_next, quo_next, qr_sel, fix_res;

    // Operand decode at accept: signedness, magnitudes, result sign, special cases.
    always_comb begin
        a_signed = (funct3 == F3_MUL) || (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                   (funct3 == F3_DIV) || (funct3 == F3_REM);
        b_signed = (funct3 == F3_MUL) || (funct3 == F3_MULH) ||
                   (funct3 == F3_DIV) || (funct3 == F3_REM);
        abs_a    = (a_signed && a[XLEN-1]) ? neg32(a) : a;
        abs_b    = (b_signed && b[XLEN-1]) ? neg32(b) : b;
        case (funct3)
            F3_MUL, F3_MULH, F3_DIV: res_sign = a[XLEN-1] ^ b[XLEN-1];
            F3_MULHSU, F3_REM:       res_sign = a[XLEN-1];
            default:                 res_sign = 1'b0;
        endcase
        is_div   = funct3[2];
        div_zero = is_div && (b == '0);
        div_ovf  = ((funct3 == F3_DIV) || (funct3 == F3_REM)) && (a == INT_MIN) && (b == ALL_ONES);
        special  = div_zero || div_ovf;
        if (div_zero) special_res = funct3[1] ? a : ALL_ONES;
        else          special_res = funct3[1] ? '0 : INT_MIN;
        accept   = (state == S_IDLE) && start && !kill;
    end

`ifdef PRV32_FAST_MUL_EN
    logic signed [XLEN:0] fa, fb;
    logic signed [63:0]   fprod;
    always_comb begin
        fa    = {a_signed & a[XLEN-1], a};
        fb    = {b_signed & b[XLEN-1], b};
        fprod = 64'(fa) * 64'(fb);
    end
`endif

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (special)     state_next = S_DONE;
                    else if (is_div) state_next = S_DIV;
                    else
`ifdef PRV32_FAST_MUL_EN
                                     state_next = S_FIX;
`else
                                     state_next = S_MUL;
`endif
                end
            end
            S_MUL, S_DIV: if (cnt == 5'(ITERS - 1)) state_next = S_FIX;
            S_FIX:        state_next = S_DONE;
            S_DONE:       state_next = S_IDLE;
            default:      state_next = S_IDLE;
        endcase
        if (kill && (state != S_IDLE)) state_next = S_IDLE;
    end

    // Right-shifting shift-add: add the multiplicand into the top half, then shift.
    always_comb begin
        mul_sum  = {1'b0, acc[63:32]} + {1'b0, (mag_b[cnt] ? mag_a : '0)};
        mul_next = {mul_sum, acc[31:1]};
    end

    prv32_div_step #(.XLEN(XLEN)) u_div_step (
        .rem      (acc[63:32]),
        .quo      (acc[31:0]),
        .divisor  (mag_b),
        .rem_next (rem_next),
        .quo_next (quo_next)
    );

    always_comb begin
        prod    = neg_q ? (~acc + 64'd1) : acc;
        qr_sel  = f3_q[1] ? acc[63:32] : acc[31:0];
        if (neg_q) qr_sel = neg32(qr_sel);
        case (f3_q)
            F3_MUL:                       fix_res = prod[31:0];
            F3_MULH, F3_MULHSU, F3_MULHU: fix_res = prod[63:32];
            default:                      fix_res = qr_sel;
        endcase
    end

    // Operand and accumulator registers carry no reset; they are always reloaded on accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            f3_q  <= funct3;
            mag_a <= abs_a;
            mag_b <= abs_b;
            neg_q <= res_sign;
            if (is_div) begin
                acc <= {32'd0, abs_a};
            end else begin
`ifdef PRV32_FAST_MUL_EN
                acc   <= fprod;
                neg_q <= 1'b0;
`else
                acc   <= '0;
`endif
            end
        end else if (state == S_MUL) begin
            acc <= mul_next;
        end else if (state == S_DIV) begin
            acc <= {rem_next, quo_next};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            result <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                cnt <= '0;
                if (special) result <= special_res;
            end else if ((state == S_MUL) || (state == S_DIV)) begin
                cnt <= cnt + 5'd1;
            end
            if ((state == S_FIX) && !kill) result <= fix_res;
        end
    end

    assign busy  = (state != S_IDLE);
    assign done  = (state == S_DONE);
    assign stall = (state == S_MUL) || (state == S_DIV) || (state == S_FIX) || accept;

endmodule

// File: tb/tb_prv32_muldiv_seq.sv
// Directed bench for prv32_muldiv_seq with an arithmetic reference model and scoreboard.
module tb_prv32_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst, start, kill;
    logic [2:0]  funct3;
    logic [31:0] a, b, result;
    logic        done, busy, stall;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_res;

    prv32_muldiv_seq #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .start(start), .kill(kill), .funct3(funct3),
        .a(a), .b(b), .result(result), .done(done), .busy(busy), .stall(stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    // Reference: plain 64-bit arithmetic plus the RISC-V divide corner rules.
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        sa = longint'($signed(x));
        sb = longint'($signed(y));
        ua = {32'd0, x};
        ub = {32'd0, y};
        p  = '0;
        case (f)
            3'd0: begin p = sa * sb;               return p[31:0];  end
            3'd1: begin p = sa * sb;               return p[63:32]; end
            3'd2: begin p = sa * longint'(ub);     return p[63:32]; end
            3'd3: begin p = ua * ub;               return p[63:32]; end
            3'd4: begin
                if (y == 32'd0) return 32'hFFFF_FFFF;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (y == 32'd0) return 32'hFFFF_FFFF;
                return x / y;
            end
            3'd6: begin
                if (y == 32'd0) return x;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (y == 32'd0) return x;
                return x % y;
            end
        endcase
    endfunction

    function automatic int exp_latency(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        if (f[2] && (y == 32'd0)) return 1;
        if ((f == 3'd4 || f == 3'd6) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
`ifdef PRV32_FAST_MUL_EN
        if (!f[2]) return 2;
`endif
        return 34;
    endfunction

    // Scoreboard: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: result %h with no op pending", result);
            end else begin
                check("result", result, exp_q.pop_front());
            end
        end
    end

    task automatic run_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y, input int hold);
        int lat, stl, want;
        bit seen;
        want = exp_latency(f, x, y);
        @(negedge clk);
        funct3 = f; a = x; b = y; start = 1'b1;
        last_res = model(f, x, y);
        exp_q.push_back(last_res);
        #1;
        stl = stall ? 1 : 0;
        @(posedge clk);
        #1;
        if (hold > 0) begin
            a = ~x; b = ~y; funct3 = f ^ 3'b001;
        end else begin
            start = 1'b0;
        end
        lat  = 1;
        seen = 1'b0;
        while (!seen && lat < 100) begin
            @(negedge clk);
            if (lat >= hold) start = 1'b0;
            if (done) begin
                seen = 1'b1;
                check("stall_on_done", {31'd0, stall}, 32'd0);
            end else begin
                if (stall) stl++;
                @(posedge clk);
                lat++;
            end
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL timeout: f3=%0d no done after %0d edges", f, lat);
        end
        check("latency", lat, want);
        check("stall_cycles", stl, want);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; kill = 1'b0; funct3 = 3'd0; a = '0; b = '0;
        last_res = '0;

        // Pin the model against hand-computed values.
        check("model_mul",    model(3'd0, 32'd7, 32'hFFFF_FFFD),        32'hFFFF_FFEB);
        check("model_mulhu",  model(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);
        check("model_mulhsu", model(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);
        check("model_mulh",   model(3'd1, 32'h8000_0000, 32'h8000_0000), 32'h4000_0000);
        check("model_div",    model(3'd4, 32'hFFFF_FFF9, 32'd2),         32'hFFFF_FFFD);
        check("model_rem",    model(3'd6, 32'hFFFF_FFF9, 32'd2),         32'hFFFF_FFFF);
        check("model_divu",   model(3'd5, 32'd100, 32'd7),               32'd14);
        check("model_remu",   model(3'd7, 32'd100, 32'd7),               32'd2);

        #12;
        check("rst_busy",   {31'd0, busy},  32'd0);
        check("rst_done",   {31'd0, done},  32'd0);
        check("rst_stall",  {31'd0, stall}, 32'd0);
        check("rst_result", result,         32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(3'd0, 32'd7,          32'hFFFF_FFFD, 0);
        run_op(3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 0);
        run_op(3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 0);
        run_op(3'd1, 32'h8000_0000,  32'h8000_0000, 0);
        run_op(3'd0, 32'h1234_5678,  32'h9ABC_DEF0, 0);
        run_op(3'd4, 32'hFFFF_FFF9,  32'd2,         0);
        run_op(3'd6, 32'hFFFF_FFF9,  32'd2,         0);
        run_op(3'd5, 32'd100,        32'd7,         0);
        run_op(3'd7, 32'd100,        32'd7,         0);
        run_op(3'd4, 32'd7,          32'hFFFF_FFFE, 0);
        run_op(3'd6, 32'hDEAD_BEEF,  32'h0000_1234, 0);
        run_op(3'd5, 32'd5,          32'd0,         0);
        run_op(3'd7, 32'd5,          32'd0,         0);
        run_op(3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 0);
        run_op(3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 0);
        run_op(3'd5, 32'hFFFF_FFFF,  32'd3,         10);

        // Kill a divide ten cycles after accept.
        @(negedge clk);
        funct3 = 3'd4; a = 32'd1000; b = 32'd3; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        kill = 1'b1;
        @(posedge clk);
        #1 kill = 1'b0;
        @(negedge clk);
        check("kill_busy",   {31'd0, busy}, 32'd0);
        check("kill_done",   {31'd0, done}, 32'd0);
        check("kill_result", result,        last_res);
        run_op(3'd7, 32'd1000, 32'd3, 0);

        // Reset in the middle of an op while start stays high.
        @(negedge clk);
        funct3 = 3'd5; a = 32'd999; b = 32'd4; start = 1'b1;
        repeat (6) @(negedge clk);
        check("mid_busy",  {31'd0, busy},  32'd1);
        check("mid_stall", {31'd0, stall}, 32'd1);
        #2;
        start = 1'b0;
        rst   = 1'b1;
        #1;
        check("rst2_busy",   {31'd0, busy},  32'd0);
        check("rst2_done",   {31'd0, done},  32'd0);
        check("rst2_stall",  {31'd0, stall}, 32'd0);
        check("rst2_result", result,         32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) begin
            @(negedge clk);
            check("post_rst_done", {31'd0, done}, 32'd0);
        end
        check("pending_ops", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
